elbeth_fetch_unit: RTL and testbench

//   Instruction-fetch stage: owns the PC and drives the instruction memory port.

---
 rtl/elbeth_fetch_unit_pkg.sv | 32 +++
 rtl/elbeth_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_elbeth_fetch_unit.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elbeth_fetch_unit_pkg.sv
// Shared definitions for the Elbeth instruction-fetch stage: NOP encoding,
// fetch exception codes, FSM states and the IF/ID slot record.
package elbeth_fetch_unit_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        EXC_NONE      = 4'd0,
        EXC_IMISALIGN = 4'd1,
        EXC_IBUS      = 4'd2
    } exc_src_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ABORT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
        exc_src_e    src;
    } if_slot_t;

    localparam if_slot_t EMPTY_SLOT = '{instr: NOP, pc: '0, exc: 1'b0, src: EXC_NONE};

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/elbeth_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory port
// and presents one slot per cycle to the IF/ID register.
module elbeth_fetch_unit
    import elbeth_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        ctrl_except_redirect,
    input  logic [31:0] ctrl_except_pc,
    input  logic        ctrl_stall,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_except,
    output logic [3:0]  if_except_src,
    output logic        if_stall_req
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  abort_addr_q, abort_addr_d;
    if_slot_t     hold_q, hold_d;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic         aligned;
    logic         fetch_req;
    logic         completion;
    if_slot_t     fetch_slot;
    if_slot_t     out_slot;

    always_comb begin
        redirect        = ctrl_except_redirect | ex_branch_taken;
        redirect_target = ctrl_except_redirect ? ctrl_except_pc : ex_branch_target;
        aligned         = (pc_q[1:0] == 2'b00);
        fetch_req       = (state_q == FETCH) && aligned;
        // A misaligned pc completes immediately without touching the bus.
        completion      = (state_q == FETCH) && (!aligned || imem_ready);

        fetch_slot = '{instr: imem_rdata, pc: pc_q, exc: 1'b0, src: EXC_NONE};
        if (!aligned) begin
            fetch_slot = '{instr: NOP, pc: pc_q, exc: 1'b1, src: EXC_IMISALIGN};
        end else if (imem_error) begin
            fetch_slot = '{instr: NOP, pc: pc_q, exc: 1'b1, src: EXC_IBUS};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_VECTOR;
            abort_addr_q <= '0;
            hold_q       <= EMPTY_SLOT;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            abort_addr_q <= abort_addr_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        abort_addr_d = abort_addr_q;
        hold_d       = hold_q;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d = redirect_target;
                    // The outstanding request cannot be withdrawn; drain it first.
                    if (fetch_req && !imem_ready) begin
                        abort_addr_d = pc_q;
                        state_d      = ABORT;
                    end
                end else if (completion) begin
                    if (ctrl_stall) begin
                        hold_d  = fetch_slot;
                        state_d = HOLD;
                    end else begin
                        pc_d = pc_plus4(pc_q);
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    hold_d  = EMPTY_SLOT;
                    state_d = FETCH;
                end else if (!ctrl_stall) begin
                    pc_d    = pc_plus4(pc_q);
                    state_d = FETCH;
                end
            end
            ABORT: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    always_comb begin
        imem_req     = 1'b0;
        imem_addr    = '0;
        out_slot     = EMPTY_SLOT;
        if_stall_req = 1'b0;

        if (rst) begin
            unique case (state_q)
                FETCH: begin
                    imem_req     = fetch_req;
                    imem_addr    = pc_q;
                    if_stall_req = !completion;
                    if (completion) begin
                        out_slot = fetch_slot;
                    end
                end
                HOLD: begin
                    out_slot = hold_q;
                end
                ABORT: begin
                    imem_req     = 1'b1;
                    imem_addr    = abort_addr_q;
                    if_stall_req = 1'b1;
                end
                default: begin
                    out_slot = EMPTY_SLOT;
                end
            endcase

            if (redirect) begin
                out_slot     = EMPTY_SLOT;
                if_stall_req = 1'b0;
            end
        end

        if_instruction = out_slot.instr;
        if_pc          = out_slot.pc;
        if_except      = out_slot.exc;
        if_except_src  = out_slot.src;
    end

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// Self-checking bench for elbeth_fetch_unit: directed scenarios plus random
// traffic compared each cycle against a behavioural model of the fetch stage.
module tb_elbeth_fetch_unit;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_error = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_target = '0;
    logic        ctrl_except_redirect = 1'b0;
    logic [31:0] ctrl_except_pc = '0;
    logic        ctrl_stall = 1'b0;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_except;
    logic [3:0]  if_except_src;
    logic        if_stall_req;

    elbeth_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .imem_addr            (imem_addr),
        .imem_req             (imem_req),
        .imem_ready           (imem_ready),
        .imem_rdata           (imem_rdata),
        .imem_error           (imem_error),
        .ex_branch_taken      (ex_branch_taken),
        .ex_branch_target     (ex_branch_target),
        .ctrl_except_redirect (ctrl_except_redirect),
        .ctrl_except_pc       (ctrl_except_pc),
        .ctrl_stall           (ctrl_stall),
        .if_instruction       (if_instruction),
        .if_pc                (if_pc),
        .if_except            (if_except),
        .if_except_src        (if_except_src),
        .if_stall_req         (if_stall_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch pointer, a pending drain of an abandoned request,
    // and a parked slot while the pipeline refuses to take it.
    logic [31:0] m_pc;
    bit          m_drain;
    logic [31:0] m_abort_addr;
    bit          m_hold;
    logic [31:0] m_h_instr, m_h_pc;
    logic        m_h_exc;
    logic [3:0]  m_h_src;

    bit          a_ready, a_stall, a_redir;
    logic [31:0] a_tgt;

    logic        e_req, e_exc, e_stall;
    logic [31:0] e_addr, e_instr, e_pc;
    logic [3:0]  e_src;
    logic [102:0] exp_v, obs_v;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_drain = 0;
        m_hold  = 0;
        m_abort_addr = '0;
    endtask

    // Drive one cycle of inputs (clock low), compute what the stage must show.
    task automatic apply(input bit ready, input bit err, input bit bt, input logic [31:0] btgt,
                         input bit cer, input logic [31:0] cpc, input bit stall);
        imem_ready           = ready;
        imem_error           = err;
        ex_branch_taken      = bt;
        ex_branch_target     = btgt;
        ctrl_except_redirect = cer;
        ctrl_except_pc       = cpc;
        ctrl_stall           = stall;
        a_ready = ready;
        a_stall = stall;
        a_redir = bt | cer;
        a_tgt   = cer ? cpc : btgt;

        e_req = 0; e_addr = '0; e_instr = NOP_W; e_pc = '0; e_exc = 0; e_src = 4'd0; e_stall = 0;
        if (rst) begin
            if (m_drain) begin
                e_req = 1; e_addr = m_abort_addr; e_stall = 1;
            end else if (m_hold) begin
                e_instr = m_h_instr; e_pc = m_h_pc; e_exc = m_h_exc; e_src = m_h_src;
            end else if (m_pc % 4 != 0) begin
                e_pc = m_pc; e_exc = 1; e_src = 4'd1;
            end else begin
                e_req = 1; e_addr = m_pc;
                if (ready) begin
                    e_pc = m_pc;
                    if (err) begin
                        e_exc = 1; e_src = 4'd2;
                    end else begin
                        e_instr = mem_word(m_pc);
                    end
                end else begin
                    e_stall = 1;
                end
            end
            if (a_redir) begin
                e_instr = NOP_W; e_pc = '0; e_exc = 0; e_src = 4'd0; e_stall = 0;
            end
        end
        imem_rdata = e_req ? mem_word(e_addr) : $urandom;
        #1;
        exp_v = {e_req, e_addr, e_instr, e_pc, e_exc, e_src, e_stall};
        obs_v = {imem_req, (e_req ? imem_addr : 32'h0), if_instruction, if_pc,
                 if_except, if_except_src, if_stall_req};
    endtask

    // Clock edge: advance the model, then return to the low phase.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            if (m_drain) begin
                if (a_redir) m_pc = a_tgt;
                if (a_ready) m_drain = 0;
            end else if (m_hold) begin
                if (a_redir) begin
                    m_pc = a_tgt; m_hold = 0;
                end else if (!a_stall) begin
                    m_pc = m_pc + 32'd4; m_hold = 0;
                end
            end else if (a_redir) begin
                if (m_pc % 4 == 0 && !a_ready) begin
                    m_drain = 1; m_abort_addr = m_pc;
                end
                m_pc = a_tgt;
            end else if (!e_stall) begin
                if (a_stall) begin
                    m_hold = 1; m_h_instr = e_instr; m_h_pc = e_pc; m_h_exc = e_exc; m_h_src = e_src;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        apply(0, 0, 0, '0, 0, '0, 0);
        advance();
        advance();
        rst = 1'b1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1, 0, 0, '0, 0, '0, 0);
            advance();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 0, '0, 0, '0, 0);
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            checks++;
            if ({imem_req, imem_addr, if_instruction, if_pc, if_except, if_except_src, if_stall_req}
                !== {1'b0, 32'h0, NOP_W, 32'h0, 1'b0, 4'h0, 1'b0}) begin
                errors++; $display("FAIL reset_outputs req=%b addr=%h ins=%h pc=%h exp zeros/NOP",
                                   imem_req, imem_addr, if_instruction, if_pc);
            end
            checks++;
            advance();
        end
        rst = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, 0, '0, 0, '0, 0);
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            checks++;
            if (imem_addr !== 32'(i * 4) || if_pc !== 32'(i * 4) || if_stall_req !== 1'b0) begin
                errors++; $display("FAIL stream_addr cyc=%0d addr=%h pc=%h stall=%b exp %h", i,
                                   imem_addr, if_pc, if_stall_req, 32'(i * 4));
            end
            checks++;
            advance();
        end
    endtask

    task automatic test_wait();
        do_reset();
        stream(4);
        for (int i = 0; i < 4; i++) begin
            apply(i == 3, 0, 0, '0, 0, '0, 0);
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL wait cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_stall_req !== (i != 3)) begin
                errors++; $display("FAIL wait_hold cyc=%0d req=%b addr=%h stall=%b exp addr 00000010",
                                   i, imem_req, imem_addr, if_stall_req);
            end
            checks++;
            advance();
        end
        apply(1, 0, 0, '0, 0, '0, 0);
        if (imem_addr !== 32'h14) begin
            errors++; $display("FAIL wait_next addr=%h exp=00000014", imem_addr);
        end
        checks++;
        advance();
    endtask

    task automatic test_hold();
        do_reset();
        stream(8);
        for (int i = 0; i < 4; i++) begin
            apply(i == 0, 0, 0, '0, 0, '0, i != 3);
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL hold cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            checks++;
            if (i > 0 && (imem_req !== 1'b0 || if_instruction !== mem_word(32'h20) || if_pc !== 32'h20)) begin
                errors++; $display("FAIL hold_slot cyc=%0d req=%b ins=%h pc=%h exp ins %h", i,
                                   imem_req, if_instruction, if_pc, mem_word(32'h20));
            end
            checks++;
            advance();
        end
        apply(1, 0, 0, '0, 0, '0, 0);
        if (imem_addr !== 32'h24 || imem_req !== 1'b1) begin
            errors++; $display("FAIL hold_next addr=%h req=%b exp=00000024", imem_addr, imem_req);
        end
        checks++;
        advance();
    endtask

    task automatic test_branch_abort();
        do_reset();
        stream(12);
        for (int i = 0; i < 5; i++) begin
            apply(i == 4, 0, i == 1, 32'h100, 0, '0, 0);
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL abort cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            checks++;
            if (imem_addr !== 32'h30 || imem_req !== 1'b1 || (i >= 1 && if_instruction !== NOP_W)) begin
                errors++; $display("FAIL abort_addr cyc=%0d addr=%h req=%b ins=%h exp addr 00000030",
                                   i, imem_addr, imem_req, if_instruction);
            end
            checks++;
            advance();
        end
        apply(1, 0, 0, '0, 0, '0, 0);
        if (imem_addr !== 32'h100 || if_pc !== 32'h100) begin
            errors++; $display("FAIL abort_next addr=%h pc=%h exp=00000100", imem_addr, if_pc);
        end
        checks++;
        advance();
    endtask

    task automatic test_redirect_priority();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            stream(3);
            apply(1, 0, 1, 32'h200, 1, 32'h80, pass == 1);
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL prio pass=%0d got=%h exp=%h", pass, obs_v, exp_v);
            end
            checks++;
            advance();
            apply(1, 0, 0, '0, 0, '0, 0);
            if (imem_addr !== 32'h80 || if_pc !== 32'h80) begin
                errors++; $display("FAIL prio_next pass=%0d addr=%h exp=00000080", pass, imem_addr);
            end
            checks++;
            advance();
        end
    endtask

    task automatic test_misalign();
        do_reset();
        stream(2);
        apply(1, 0, 1, 32'h102, 0, '0, 0);
        advance();
        apply(1, 0, 0, '0, 0, '0, 0);
        if ({imem_req, if_instruction, if_pc, if_except, if_except_src, if_stall_req}
            !== {1'b0, NOP_W, 32'h102, 1'b1, 4'd1, 1'b0}) begin
            errors++; $display("FAIL misalign req=%b ins=%h pc=%h exc=%b src=%0d stall=%b exp 0/NOP/102/1/1/0",
                               imem_req, if_instruction, if_pc, if_except, if_except_src, if_stall_req);
        end
        checks++;
        advance();
    endtask

    task automatic test_bus_error();
        do_reset();
        stream(16);
        apply(1, 1, 0, '0, 0, '0, 0);
        if ({if_instruction, if_pc, if_except, if_except_src} !== {NOP_W, 32'h40, 1'b1, 4'd2}) begin
            errors++; $display("FAIL bus_error ins=%h pc=%h exc=%b src=%0d exp NOP/40/1/2",
                               if_instruction, if_pc, if_except, if_except_src);
        end
        checks++;
        advance();
        apply(1, 0, 0, '0, 0, '0, 0);
        if (imem_addr !== 32'h44) begin
            errors++; $display("FAIL bus_error_next addr=%h exp=00000044", imem_addr);
        end
        checks++;
        advance();
    endtask

    task automatic test_wrap();
        do_reset();
        apply(1, 0, 1, 32'hFFFF_FFFC, 0, '0, 0);
        advance();
        apply(1, 0, 0, '0, 0, '0, 0);
        if (imem_addr !== 32'hFFFF_FFFC || if_pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_top addr=%h exp=fffffffc", imem_addr);
        end
        checks++;
        advance();
        apply(1, 0, 0, '0, 0, '0, 0);
        if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            errors++; $display("FAIL wrap_zero addr=%h req=%b exp=00000000", imem_addr, imem_req);
        end
        checks++;
        advance();
    endtask

    task automatic test_reset_mid_abort();
        do_reset();
        stream(5);
        apply(0, 0, 1, 32'h300, 0, '0, 0);
        advance();
        apply(0, 0, 0, '0, 0, '0, 0);
        if (imem_addr !== 32'h14 || imem_req !== 1'b1 || if_stall_req !== 1'b1) begin
            errors++; $display("FAIL rst_abort_pre addr=%h req=%b exp=00000014", imem_addr, imem_req);
        end
        checks++;
        #2;
        rst = 1'b0;
        #1;
        if ({imem_req, imem_addr, if_instruction, if_pc, if_except, if_except_src, if_stall_req}
            !== {1'b0, 32'h0, NOP_W, 32'h0, 1'b0, 4'h0, 1'b0}) begin
            errors++; $display("FAIL rst_abort_async req=%b addr=%h ins=%h stall=%b exp zeros/NOP",
                               imem_req, imem_addr, if_instruction, if_stall_req);
        end
        checks++;
        model_reset();
        advance();
        rst = 1'b1;
        apply(1, 0, 0, '0, 0, '0, 0);
        if (imem_addr !== 32'h0 || imem_req !== 1'b1 || if_pc !== 32'h0) begin
            errors++; $display("FAIL rst_abort_restart addr=%h req=%b exp=00000000", imem_addr, imem_req);
        end
        checks++;
        advance();
    endtask

    task automatic test_random();
        logic [31:0] t1, t2;
        bit rdy, er, bt, cer, st;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 1) == 1);
            er  = rdy && ($urandom_range(0, 9) == 0);
            bt  = ($urandom_range(0, 11) == 0);
            cer = ($urandom_range(0, 24) == 0);
            st  = ($urandom_range(0, 3) == 0);
            t1  = $urandom & 32'h0000_0FFC;
            t2  = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 7) == 0) t1 = t1 | 32'($urandom_range(1, 3));
            apply(rdy, er, bt, t1, cer, t2, st);
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            end
            checks++;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait();
        test_hold();
        test_branch_abort();
        test_redirect_priority();
        test_misalign();
        test_bus_error();
        test_wrap();
        test_reset_mid_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout bench did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
